// File: rtl/scoreboard_clear_arbiter_pkg.sv
// Shared types and defaults for the scoreboard clear / long-latency writeback arbiter.
package scoreboard_clear_arbiter_pkg;

  localparam int RV32_reg_addr_width_gp = 5;
  localparam int data_width_gp          = 32;
  localparam int max_out_gp             = 16;
  localparam int out_cnt_width_gp       = $clog2(max_out_gp + 1);

  typedef struct packed {
    logic [RV32_reg_addr_width_gp-1:0] id;
    logic [data_width_gp-1:0]          data;
  } comp_req_s;

  typedef enum logic {
    FENCE_IDLE  = 1'b0,
    FENCE_DRAIN = 1'b1
  } fence_state_e;

endpackage

// File: rtl/scoreboard_clear_arbiter_if.sv
// Completion request bundle: packed per-source valid/id/data plus the one-hot yumi return.
interface scoreboard_clear_arbiter_if
  import scoreboard_clear_arbiter_pkg::*;
#(
  parameter int num_req_p    = 3,
  parameter int id_width_p   = RV32_reg_addr_width_gp,
  parameter int data_width_p = data_width_gp
);

  logic [num_req_p-1:0]              req_v_i;
  logic [num_req_p*id_width_p-1:0]   req_id_i;
  logic [num_req_p*data_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]              req_yumi_o;

  modport master (output req_v_i, output req_id_i, output req_data_i, input req_yumi_o);
  modport slave  (input req_v_i, input req_id_i, input req_data_i, output req_yumi_o);

endinterface

// File: rtl/scoreboard_clear_arbiter_rr_arbiter.sv
// Grant logic for the completion sources. Defining SB_CLEAR_ARB_FIXED_PRIORITY_EN
// swaps the round-robin pointer for a lowest-index-wins priority encoder.
module sb_rr_arbiter
  import scoreboard_clear_arbiter_pkg::*;
#(
  parameter int num_req_p = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] req_v,
  input  logic                 block,
  output logic [num_req_p-1:0] grant
);

  logic [num_req_p-1:0] req_ok;
  logic                 found;

  assign req_ok = req_v & {num_req_p{~block}};

`ifdef SB_CLEAR_ARB_FIXED_PRIORITY_EN

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && req_ok[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end

`else

  localparam int ptr_w_lp = $clog2(num_req_p);
  localparam int sum_w_lp = ptr_w_lp + 1;

  logic [ptr_w_lp-1:0] rr_ptr;
  logic [ptr_w_lp-1:0] ptr_n;
  logic [ptr_w_lp-1:0] idx;
  logic [sum_w_lp-1:0] sum;

  // Scan sources starting at rr_ptr, wrapping modulo num_req_p; the pointer moves past the winner.
  always_comb begin
    grant = '0;
    found = 1'b0;
    ptr_n = rr_ptr;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      sum = sum_w_lp'(rr_ptr) + sum_w_lp'(i);
      if (sum >= sum_w_lp'(num_req_p)) sum = sum - sum_w_lp'(num_req_p);
      idx = sum[ptr_w_lp-1:0];
      if (!found && req_ok[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_n      = (idx == ptr_w_lp'(num_req_p - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_ptr <= '0;
    else if (found) rr_ptr <= ptr_n;
  end

`endif

endmodule

// File: rtl/scoreboard_clear_arbiter.sv
// Shares the scoreboard clear port and long-latency RF write port among completion sources,
// tracks outstanding scored ops and runs the fence drain FSM. Option: SB_CLEAR_ARB_FIXED_PRIORITY_EN.
module scoreboard_clear_arbiter
  import scoreboard_clear_arbiter_pkg::*;
#(
  parameter int num_req_p    = 3,
  parameter int id_width_p   = RV32_reg_addr_width_gp,
  parameter int data_width_p = data_width_gp,
  parameter int max_out_p    = max_out_gp
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  scoreboard_clear_arbiter_if.slave        req_if,
  input  logic                             pipe_wb_v_i,
  input  logic                             score_i,
  input  logic                             fence_i,
  output logic                             fence_busy_o,
  output logic                             clear_o,
  output logic [id_width_p-1:0]            clear_id_o,
  output logic                             rf_wen_o,
  output logic [id_width_p-1:0]            rf_waddr_o,
  output logic [data_width_p-1:0]          rf_wdata_o,
  output logic [$clog2(max_out_p+1)-1:0]   outstanding_o,
  output logic                             outstanding_full_o
);

  localparam int cnt_w_lp = $clog2(max_out_p + 1);

  logic [num_req_p-1:0]              req_v;
  logic [num_req_p*id_width_p-1:0]   req_id;
  logic [num_req_p*data_width_p-1:0] req_data;
  logic [num_req_p-1:0]              grant;
  logic [id_width_p-1:0]             sel_id;
  logic [data_width_p-1:0]           sel_data;
  logic                              stage_v;
  logic [id_width_p-1:0]             stage_id;
  logic [data_width_p-1:0]           stage_data;
  logic [cnt_w_lp-1:0]               cnt;
  logic                              inc, dec, full, empty, pending;
  fence_state_e                      state, state_n;

  assign req_v    = req_if.req_v_i;
  assign req_id   = req_if.req_id_i;
  assign req_data = req_if.req_data_i;

  sb_rr_arbiter #(.num_req_p(num_req_p)) arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_v   (req_v),
    .block   (pipe_wb_v_i),
    .grant   (grant)
  );

  assign req_if.req_yumi_o = grant;

  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (grant[k]) begin
        sel_id   = req_id[k*id_width_p +: id_width_p];
        sel_data = req_data[k*data_width_p +: data_width_p];
      end
    end
  end

  // Selected id/data are zero without a grant, so the stage reads all-zero in idle cycles.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_v    <= 1'b0;
      stage_id   <= '0;
      stage_data <= '0;
    end else begin
      stage_v    <= |grant;
      stage_id   <= sel_id;
      stage_data <= sel_data;
    end
  end

  assign clear_o    = stage_v;
  assign clear_id_o = stage_id;
  assign rf_wen_o   = stage_v;
  assign rf_waddr_o = stage_id;
  assign rf_wdata_o = stage_data;

  assign inc   = score_i;
  assign dec   = stage_v;
  assign full  = (cnt == cnt_w_lp'(max_out_p));
  assign empty = (cnt == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + cnt_w_lp'(1);
    else if (dec && !inc && !empty) cnt <= cnt - cnt_w_lp'(1);
  end

  assign outstanding_o      = cnt;
  assign outstanding_full_o = full;
  assign pending            = !empty || stage_v;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= FENCE_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n      = state;
    fence_busy_o = 1'b0;
    case (state)
      FENCE_IDLE: begin
        fence_busy_o = fence_i && pending;
        if (fence_i && pending) state_n = FENCE_DRAIN;
      end
      FENCE_DRAIN: begin
        fence_busy_o = 1'b1;
        if (!pending) state_n = FENCE_IDLE;
      end
      default: state_n = FENCE_IDLE;
    endcase
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !(inc && !dec && full));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i) !(dec && !inc && empty));

  for (genvar k = 0; k < num_req_p; k++) begin : g_id_chk
    a_nonzero_id: assert property (@(posedge clk_i) disable iff (reset_i)
      req_v[k] |-> (req_id[k*id_width_p +: id_width_p] != '0));
  end

endmodule

// File: tb/tb_scoreboard_clear_arbiter.sv
// Directed bench for scoreboard_clear_arbiter; clears are checked by a queue-driven monitor.
module tb_scoreboard_clear_arbiter;
  import scoreboard_clear_arbiter_pkg::*;

  localparam int num_req_lp = 3;
  localparam int id_w_lp    = RV32_reg_addr_width_gp;
  localparam int data_w_lp  = data_width_gp;

  logic clk = 1'b0;
  logic reset;
  logic pipe_wb_v, score, fence;
  logic fence_busy, clear, rf_wen, outstanding_full;
  logic [id_w_lp-1:0] clear_id, rf_waddr;
  logic [data_w_lp-1:0] rf_wdata;
  logic [out_cnt_width_gp-1:0] outstanding;

  comp_req_s exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  scoreboard_clear_arbiter_if #(
    .num_req_p(num_req_lp), .id_width_p(id_w_lp), .data_width_p(data_w_lp)
  ) req_bus ();

  scoreboard_clear_arbiter #(
    .num_req_p(num_req_lp), .id_width_p(id_w_lp), .data_width_p(data_w_lp), .max_out_p(16)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .req_if             (req_bus),
    .pipe_wb_v_i        (pipe_wb_v),
    .score_i            (score),
    .fence_i            (fence),
    .fence_busy_o       (fence_busy),
    .clear_o            (clear),
    .clear_id_o         (clear_id),
    .rf_wen_o           (rf_wen),
    .rf_waddr_o         (rf_waddr),
    .rf_wdata_o         (rf_wdata),
    .outstanding_o      (outstanding),
    .outstanding_full_o (outstanding_full)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic f, input logic p);
    score     = s;
    fence     = f;
    pipe_wb_v = p;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [id_w_lp-1:0] id, input logic [data_w_lp-1:0] data);
    req_bus.req_v_i[k] = 1'b1;
    req_bus.req_id_i[k*id_w_lp +: id_w_lp] = id;
    req_bus.req_data_i[k*data_w_lp +: data_w_lp] = data;
  endtask

  task automatic push_exp(input logic [id_w_lp-1:0] id, input logic [data_w_lp-1:0] data);
    comp_req_s e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Every cycle the DUT presents a clear, it must match the oldest expected completion.
  task automatic monitor();
    comp_req_s e;
    forever begin
      @(negedge clk);
      if (clear) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL clear_unexpected: got clear id %0d, required no clear", clear_id);
        end else begin
          e = exp_q.pop_front();
          check_output("mon_clear_id", clear_id, e.id);
          check_output("mon_rf_waddr", rf_waddr, e.id);
          check_output("mon_rf_wdata", rf_wdata, e.data);
          check_output("mon_rf_wen", rf_wen, 1);
        end
      end
    end
  endtask

  initial begin
    logic [2:0] y;
    logic [2:0] rr_order [3];
    logic [2:0] mix_order [4];

    reset = 1'b1;
    apply_stimulus(0, 0, 0);
    req_bus.req_v_i    = '0;
    req_bus.req_id_i   = '0;
    req_bus.req_data_i = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check_output("reset_clear", clear, 0);
    check_output("reset_rf_wen", rf_wen, 0);
    check_output("reset_clear_id", clear_id, 0);
    check_output("reset_rf_wdata", rf_wdata, 0);
    check_output("reset_outstanding", outstanding, 0);
    check_output("reset_full", outstanding_full, 0);
    check_output("reset_fence_busy", fence_busy, 0);
    check_output("reset_yumi", req_bus.req_yumi_o, 0);

    apply_stimulus(1, 0, 0);
    repeat (3) next_cycle();
    apply_stimulus(0, 0, 0);
    @(negedge clk);
    check_output("score3_count", outstanding, 3);
    check_output("score3_full", outstanding_full, 0);

    // Three simultaneous sources must be served 0, 1, 2.
    next_cycle();
    set_src(0, 5'd5, 32'hD000_0005);
    set_src(1, 5'd6, 32'hD000_0006);
    set_src(2, 5'd7, 32'hD000_0007);
    push_exp(5'd5, 32'hD000_0005);
    push_exp(5'd6, 32'hD000_0006);
    push_exp(5'd7, 32'hD000_0007);
    rr_order[0] = 3'b001;
    rr_order[1] = 3'b010;
    rr_order[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      y = req_bus.req_yumi_o;
      check_output("rr_yumi", y, rr_order[i]);
      check_output("clear_latency", clear, (i > 0) ? 1 : 0);
      next_cycle();
      req_bus.req_v_i = req_bus.req_v_i & ~y;
    end
    @(negedge clk);
    check_output("last_clear", clear, 1);
    next_cycle();
    @(negedge clk);
    check_output("drain_count", outstanding, 0);

    // Pipeline writeback blocks grants.
    apply_stimulus(1, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 1);
    set_src(1, 5'd9, 32'hD000_0009);
    push_exp(5'd9, 32'hD000_0009);
    repeat (2) begin
      @(negedge clk);
      check_output("pipe_wb_yumi", req_bus.req_yumi_o, 0);
      check_output("pipe_wb_clear", clear, 0);
      next_cycle();
    end
    apply_stimulus(0, 0, 0);
    @(negedge clk);
    y = req_bus.req_yumi_o;
    check_output("pipe_release_yumi", y, 3'b010);
    next_cycle();
    req_bus.req_v_i = req_bus.req_v_i & ~y;
    @(negedge clk);
    check_output("pipe_release_clear", clear, 1);
    next_cycle();
    @(negedge clk);
    check_output("pipe_count", outstanding, 0);

    // Score and clear in the same cycle at count 4.
    apply_stimulus(1, 0, 0);
    repeat (4) next_cycle();
    apply_stimulus(0, 0, 0);
    set_src(2, 5'd3, 32'hD000_0003);
    push_exp(5'd3, 32'hD000_0003);
    @(negedge clk);
    y = req_bus.req_yumi_o;
    check_output("wrap_yumi", y, 3'b100);
    next_cycle();
    req_bus.req_v_i = req_bus.req_v_i & ~y;
    apply_stimulus(1, 0, 0);
    @(negedge clk);
    check_output("both_clear", clear, 1);
    check_output("both_count_before", outstanding, 4);
    next_cycle();
    apply_stimulus(0, 0, 0);
    @(negedge clk);
    check_output("both_count_after", outstanding, 4);

    apply_stimulus(1, 0, 0);
    repeat (11) next_cycle();
    apply_stimulus(0, 0, 0);
    @(negedge clk);
    check_output("count15", outstanding, 15);
    check_output("full15", outstanding_full, 0);
    apply_stimulus(1, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0);
    @(negedge clk);
    check_output("count16", outstanding, 16);
    check_output("full16", outstanding_full, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_output("full_reset_count", outstanding, 0);
    check_output("full_reset_full", outstanding_full, 0);

    // Fence at count 2 drains through two clears.
    apply_stimulus(1, 0, 0);
    repeat (2) next_cycle();
    apply_stimulus(0, 1, 0);
    @(negedge clk);
    check_output("fence_count", outstanding, 2);
    check_output("fence_busy_req", fence_busy, 1);
    next_cycle();
    apply_stimulus(0, 0, 0);
    set_src(0, 5'd10, 32'hD000_000A);
    set_src(1, 5'd11, 32'hD000_000B);
    push_exp(5'd10, 32'hD000_000A);
    push_exp(5'd11, 32'hD000_000B);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("fence_busy_drain", fence_busy, 1);
      y = req_bus.req_yumi_o;
      check_output("fence_yumi", y, (i == 0) ? 3'b001 : 3'b010);
      next_cycle();
      req_bus.req_v_i = req_bus.req_v_i & ~y;
    end
    @(negedge clk);
    check_output("fence_busy_second_clear", fence_busy, 1);
    next_cycle();
    @(negedge clk);
    check_output("fence_busy_zero_count", fence_busy, 1);
    check_output("fence_zero_count", outstanding, 0);
    next_cycle();
    @(negedge clk);
    check_output("fence_busy_release", fence_busy, 0);
    next_cycle();
    apply_stimulus(0, 1, 0);
    @(negedge clk);
    check_output("fence_idle_busy", fence_busy, 0);
    next_cycle();
    apply_stimulus(0, 0, 0);
    @(negedge clk);
    check_output("fence_idle_stays", fence_busy, 0);

    // Reset while draining with count 5 and a valid output stage.
    apply_stimulus(1, 0, 0);
    repeat (5) next_cycle();
    apply_stimulus(0, 1, 0);
    @(negedge clk);
    check_output("drain5_count", outstanding, 5);
    check_output("drain5_busy", fence_busy, 1);
    next_cycle();
    apply_stimulus(0, 0, 0);
    set_src(2, 5'd12, 32'hD000_000C);
    push_exp(5'd12, 32'hD000_000C);
    @(negedge clk);
    check_output("drain5_state_busy", fence_busy, 1);
    y = req_bus.req_yumi_o;
    check_output("drain5_yumi", y, 3'b100);
    next_cycle();
    req_bus.req_v_i = req_bus.req_v_i & ~y;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_output("midreset_clear", clear, 0);
    check_output("midreset_count", outstanding, 0);
    check_output("midreset_busy", fence_busy, 0);
    check_output("midreset_clear_id", clear_id, 0);

    // Sources 0 and 2 held continuously valid.
    apply_stimulus(1, 0, 0);
    repeat (4) next_cycle();
    apply_stimulus(0, 0, 0);
    set_src(0, 5'd13, 32'hD000_000D);
    set_src(2, 5'd14, 32'hD000_000E);
`ifdef SB_CLEAR_ARB_FIXED_PRIORITY_EN
    mix_order[0] = 3'b001;
    mix_order[1] = 3'b001;
    mix_order[2] = 3'b001;
    mix_order[3] = 3'b001;
    push_exp(5'd13, 32'hD000_000D);
    push_exp(5'd13, 32'hD000_000D);
    push_exp(5'd13, 32'hD000_000D);
    push_exp(5'd13, 32'hD000_000D);
`else
    mix_order[0] = 3'b001;
    mix_order[1] = 3'b100;
    mix_order[2] = 3'b001;
    mix_order[3] = 3'b100;
    push_exp(5'd13, 32'hD000_000D);
    push_exp(5'd14, 32'hD000_000E);
    push_exp(5'd13, 32'hD000_000D);
    push_exp(5'd14, 32'hD000_000E);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("held_yumi", req_bus.req_yumi_o, mix_order[i]);
      next_cycle();
    end
    req_bus.req_v_i = '0;
    @(negedge clk);
    check_output("held_last_clear", clear, 1);
    next_cycle();
    @(negedge clk);
    check_output("held_count", outstanding, 0);
    check_output("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scoreboard_clear_arbiter.md
Name: scoreboard_clear_arbiter

Overview:
- Shares the single scoreboard clear port and the long-latency RF write port among N completion sources (remote-load return, integer divider, FPU).
- Sources are arbitrated round-robin; one winner per cycle is registered and driven to the scoreboard clear port and the RF write port.
- Counts outstanding scored operations and provides a drain/fence FSM for the pipeline (fence, barrier, CSR flush).

Parameters:
- num_req_p, 3, number of completion requesters (≥2).
- id_width_p, RV32_reg_addr_width_gp, register-id width.
- data_width_p, 32, writeback data width.
- max_out_p, 16, max outstanding scored ops; counter width is $clog2(max_out_p+1).

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- req_v_i  input  num_req_p  per-source completion valid.
- req_id_i  input  num_req_p*id_width_p  destination register id per source; source k occupies bits [k*id_width_p +: id_width_p].
- req_data_i  input  num_req_p*data_width_p  writeback data per source, packed the same way.
- req_yumi_o  output  num_req_p  one-hot: the request is consumed this cycle.
- pipe_wb_v_i  input  1  main pipeline uses the RF write port this cycle; no grant is issued.
- score_i  input  1  pipeline scores a long-latency op (nonzero dest only).
- fence_i  input  1  fence request.
- fence_busy_o  output  1  pipeline must stall the fence.
- clear_o  output  1  scoreboard clear strobe.
- clear_id_o  output  id_width_p  register to clear.
- rf_wen_o  output  1  RF write enable.
- rf_waddr_o  output  id_width_p  RF write address.
- rf_wdata_o  output  data_width_p  RF write data.
- outstanding_o  output  counter width  current outstanding count.
- outstanding_full_o  output  1  count == max_out_p.

Behaviour:
- Reset: all outputs 0; RR pointer 0; counter 0; FSM in IDLE.
- Arbitration (combinational):
  - If pipe_wb_v_i = 1, req_yumi_o = 0.
  - Otherwise grant the first valid source at or after rr_ptr, wrapping modulo num_req_p.
  - The grant is the yumi; a source holds valid, id and data until it sees yumi.
- RR pointer: on a grant to source k, next rr_ptr = (k+1) mod num_req_p. Unchanged when there is no grant.
- Output stage, 1-cycle latency:
  - A granted request is registered; next cycle clear_o = rf_wen_o = 1, with clear_id_o = rf_waddr_o = the granted id and rf_wdata_o = the granted data.
  - Outputs are 0 in cycles after no grant.
- Counter:
  - +1 on score_i.
  - −1 when the output stage asserts clear_o.
  - Both in the same cycle: unchanged.
  - score_i while full: illegal (assertion); the counter saturates.
  - Decrement at 0: illegal (assertion); the counter stays 0.
- req_id = 0 on any valid request: illegal (assertion). The scoreboard never scores x0.
- Fence FSM, states IDLE and DRAIN:
  - IDLE→DRAIN on fence_i when the counter ≠ 0 or the output stage is valid.
  - DRAIN→IDLE when the counter = 0 and the output stage is empty.
  - fence_busy_o = (state==DRAIN) | (fence_i & (counter≠0 | stage valid)), combinational.
  - fence_i with nothing outstanding: fence_busy_o = 0 and no state change.
- Reset mid-operation: the output stage is dropped, the counter is zeroed, and the FSM returns to IDLE. In-flight requesters are reset by the same reset_i.

Optional Feature:
- Macro SB_CLEAR_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; the rr_ptr register is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - the constant for the counter width;
  - a typedef for a packed completion request struct {id, data};
  - a typedef for the fence FSM state enum.
- One sub-module: sb_rr_arbiter, the round-robin grant and pointer logic, parameterised on num_req_p. The fixed-priority macro selects a priority encoder in its place.

Test Plan:
- Reset, then idle: all outputs 0 and outstanding_o = 0. score_i for 3 cycles → outstanding_o = 3, outstanding_full_o = 0.
- Sources 0, 1 and 2 valid simultaneously with ids 5, 6, 7 and held: yumi order 0, 1, 2 over three cycles. clear_id_o sequence 5, 6, 7, each one cycle after its yumi. Count 3→0.
- pipe_wb_v_i high for 2 cycles with source 1 valid: yumi = 0 for both cycles. Source 1 is granted on the first cycle after pipe_wb_v_i drops.
- score_i and clear_o in the same cycle at count 4 → count stays 4.
- Fill to max_out_p = 16 → outstanding_full_o = 1.
- fence_i at count 2: fence_busy_o = 1 and the FSM enters DRAIN. Busy holds until the second clear; it deasserts in the cycle after the count reaches 0 with the output stage empty.
- reset_i asserted while the FSM is in DRAIN with count 5 → next cycle: IDLE, count 0, clear_o = 0.
- With SB_CLEAR_ARB_FIXED_PRIORITY_EN defined and sources 0 and 2 continuously valid → source 0 is granted every cycle.
